// File: rtl/datmem_pkg.sv
// -----------------------------------------------------------------------------
// datmem_pkg
// Types and helper functions shared by the synchronous data memory.
//   dm_state_t   : controller state (array clear sweep, then normal service).
//   dm_rsp_t     : registered response flags. The read data is carried
//                  separately because its width is a per-instance parameter.
//   dm_lanes     : byte lanes per data word.
//   dm_lane_bits : byte-offset bits inside a word, log2(DWIDTH/8).
//   dm_idx_width : word-index width, log2(DEPTH).
// Optional build macro used by datmem_sync: DATMEM_ZERO_LOCK_EN.
// -----------------------------------------------------------------------------
package datmem_pkg;

  typedef enum logic [0:0] {
    DM_INIT = 1'b0,
    DM_RUN  = 1'b1
  } dm_state_t;

  typedef struct packed {
    logic valid;
    logic err;
  } dm_rsp_t;

  function automatic int dm_lanes(input int dwidth);
    return dwidth / 8;
  endfunction

  function automatic int dm_lane_bits(input int dwidth);
    return $clog2(dwidth / 8);
  endfunction

  function automatic int dm_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/datmem_array.sv
// -----------------------------------------------------------------------------
// datmem_array
// Plain DEPTH x DWIDTH single-port RAM with per-byte write enables and a
// registered read port. The read register is cleared by rst and returns to
// zero on every cycle without a read, so it can drive a response bus directly.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (read register only)
//   we_i     in   write this cycle
//   re_i     in   read this cycle (result visible next cycle)
//   idx_i    in   word index
//   wdata_i  in   write data
//   be_i     in   byte-lane write enables
//   rdata_o  out  registered read data
// -----------------------------------------------------------------------------
module datmem_array
  import datmem_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 128,
  parameter int IWIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic                   re_i,
  input  logic [IWIDTH-1:0]      idx_i,
  input  logic [DWIDTH-1:0]      wdata_i,
  input  logic [DWIDTH/8-1:0]    be_i,
  output logic [DWIDTH-1:0]      rdata_o
);

  localparam int NB = dm_lanes(DWIDTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  // Byte-lane write into the storage array.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) begin
          mem_q[idx_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
        end
      end
    end
  end

  // Registered read; idles at zero when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/datmem_sync.sv
// -----------------------------------------------------------------------------
// datmem_sync
// Synchronous, byte-addressed, single-port data memory for the MEM stage.
// After reset the whole array is swept to zero (one word per cycle) before
// requests are accepted. Each accepted request produces exactly one response
// on the following cycle; misaligned or out-of-range requests are answered
// with rsp_err and leave the array untouched.
// Build option: define DATMEM_ZERO_LOCK_EN to hardwire word 0 to zero
// (writes to it are rejected with rsp_err, reads return zero).
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_wdata  in   write data
//   req_be     in   byte-lane write enables
//   rsp_valid  out  one-cycle response strobe per accepted request
//   rsp_rdata  out  read data (zero unless a good read is responding)
//   rsp_err    out  request rejected
// -----------------------------------------------------------------------------
module datmem_sync
  import datmem_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 128,
  parameter int AWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [AWIDTH-1:0]   req_addr,
  input  logic [DWIDTH-1:0]   req_wdata,
  input  logic [DWIDTH/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DWIDTH-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB = dm_lanes(DWIDTH);
  localparam int LB = dm_lane_bits(DWIDTH);
  localparam int IW = dm_idx_width(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  dm_state_t         state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              ready_q;
  dm_rsp_t           rsp_q, rsp_d;

  logic [AWIDTH-1:0] word_full;
  logic [IW-1:0]     req_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              zero_word;
  logic              req_err;
  logic              acc;
  logic              sweep_we;

  logic              arr_we;
  logic              arr_re;
  logic [IW-1:0]     arr_idx;
  logic [DWIDTH-1:0] arr_wdata;
  logic [NB-1:0]     arr_be;
  logic [DWIDTH-1:0] arr_rdata;

  // Address decode of the request currently presented.
  always_comb begin
    word_full    = req_addr >> LB;
    req_idx      = word_full[IW-1:0];
    misaligned   = |req_addr[LB-1:0];
    out_of_range = (word_full >= AWIDTH'(DEPTH));
`ifdef DATMEM_ZERO_LOCK_EN
    zero_word    = ~out_of_range & (req_idx == '0);
`else
    zero_word    = 1'b0;
`endif
    // A locked word 0 only rejects writes; reads of it simply return zero.
    req_err      = misaligned | out_of_range | (zero_word & req_we);
  end

  // rst has priority: a request seen in a reset cycle is not accepted.
  assign acc = req_valid & ready_q & ~rst;

  // Controller next state: clear sweep in INIT, then stay in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    case (state_q)
      DM_INIT: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + IW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = DM_RUN;
        end else begin
          state_d = DM_INIT;
        end
      end
      DM_RUN: begin
        cnt_d   = '0;
        state_d = DM_RUN;
      end
      default: begin
        cnt_d   = '0;
        state_d = DM_INIT;
      end
    endcase
  end

  // Array port steering: sweep owns the port in INIT, requests in RUN.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_idx   = req_idx;
    arr_wdata = req_wdata;
    arr_be    = req_be;
    if (sweep_we) begin
      arr_we    = ~rst;
      arr_idx   = cnt_q;
      arr_wdata = '0;
      arr_be    = '1;
    end else begin
      arr_we = acc & req_we & ~req_err;
      // Reads of a locked word 0 are not issued so the zero-idle read
      // register supplies the hardwired zero.
      arr_re = acc & ~req_we & ~req_err & ~zero_word;
    end
  end

  // Response flags for the cycle after an accept.
  always_comb begin
    rsp_d.valid = acc;
    rsp_d.err   = acc & req_err;
  end

  // Controller and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DM_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == DM_RUN);
      rsp_q   <= rsp_d;
    end
  end

  datmem_array #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .IWIDTH (IW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .idx_i   (arr_idx),
    .wdata_i (arr_wdata),
    .be_i    (arr_be),
    .rdata_o (arr_rdata)
  );

  assign req_ready = ready_q;
  assign rsp_valid = rsp_q.valid;
  assign rsp_err   = rsp_q.err;
  assign rsp_rdata = arr_rdata;

endmodule

// File: tb/tb_datmem_sync.sv
// -----------------------------------------------------------------------------
// tb_datmem_sync
// Self-checking bench for datmem_sync (default parameters). Directed table of
// request/response records, hand-written reset sequences, then randomized
// traffic checked against a word-array reference model.
// Honours DATMEM_ZERO_LOCK_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_datmem_sync;

  localparam int DW  = 32;
  localparam int DEP = 128;
  localparam int AW  = 32;
  localparam int NB  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NB-1:0] req_be;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model [DEP];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] be;
    logic          err;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl [16];

  always #5 clk = ~clk;

  datmem_sync #(.DWIDTH(DW), .DEPTH(DEP), .AWIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour: byte address -> word, error rules, byte-lane merge.
  task automatic model_xact(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [NB-1:0] be,
                            output logic err, output logic [DW-1:0] rdata);
    longint unsigned a;
    longint unsigned w;
    bit lock;
    a = addr;
    w = a / 4;
    lock = 1'b0;
`ifdef DATMEM_ZERO_LOCK_EN
    lock = we && (w == 0);
`endif
    err = (a % 4 != 0) || (w >= DEP) || lock;
    rdata = '0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < NB; k++) begin
          if (be[k]) model[int'(w)][k*8 +: 8] = wdata[k*8 +: 8];
        end
      end else begin
        rdata = model[int'(w)];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEP; i++) model[i] = '0;
  endtask

  // Present a request (called #1 after an edge), check the response after the accept edge.
  task automatic xact(input string name, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [NB-1:0] be,
                      input logic exp_err, input logic [DW-1:0] exp_rdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    chk({name, " ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    chk({name, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({name, " rsp_err"}, 64'(rsp_err), 64'(exp_err));
    chk({name, " rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
  endtask

  task automatic idle(input string name);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk({name, " rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({name, " rsp_err"}, 64'(rsp_err), 64'd0);
    chk({name, " rsp_rdata"}, 64'(rsp_rdata), 64'd0);
  endtask

  // Called #1 after the first edge with rst high->low pending; counts the sweep.
  task automatic init_poll(input string name);
    chk({name, " ready c0"}, 64'(req_ready), 64'd0);
    for (int k = 1; k <= DEP; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s ready c%0d", name, k), 64'(req_ready), 64'(k == DEP));
      chk($sformatf("%s no rsp c%0d", name, k), 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          e;
    logic [DW-1:0] r;
    logic          rwe;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rwdata;
    logic [NB-1:0] rbe;
    int            sel;

    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'h10,  32'h000000AA, 4'b0001, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 1'b0, 32'hDEADBEAA};
    tbl[3]  = '{1'b1, 32'h20,  32'h12345678, 4'b1111, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h20,  32'h0,        4'b0000, 1'b0, 32'h12345678};
    tbl[5]  = '{1'b0, 32'h13,  32'h0,        4'b0000, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 32'h200, 32'h0,        4'b0000, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 32'h13,  32'hFFFFFFFF, 4'b1111, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 32'h200, 32'hFFFFFFFF, 4'b1111, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 1'b0, 32'hDEADBEAA};
    tbl[10] = '{1'b1, 32'h10,  32'h11111111, 4'b0000, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h10,  32'h0,        4'b0000, 1'b0, 32'hDEADBEAA};
`ifdef DATMEM_ZERO_LOCK_EN
    tbl[12] = '{1'b1, 32'h0,   32'hFFFFFFFF, 4'b1111, 1'b1, 32'h0};
    tbl[13] = '{1'b0, 32'h0,   32'h0,        4'b0000, 1'b0, 32'h0};
`else
    tbl[12] = '{1'b1, 32'h0,   32'hFFFFFFFF, 4'b1111, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 32'h0,   32'h0,        4'b0000, 1'b0, 32'hFFFFFFFF};
`endif
    tbl[14] = '{1'b1, 32'h1FC, 32'hCAFEBEEF, 4'b1100, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 32'h1FC, 32'h0,        4'b0000, 1'b0, 32'hCAFE0000};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset rsp_err",   64'(rsp_err),   64'd0);

    // Release reset with a read held during the sweep.
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    init_poll("init");
    @(posedge clk); #1;
    chk("held read rsp_valid", 64'(rsp_valid), 64'd1);
    chk("held read rsp_err",   64'(rsp_err),   64'd0);
    chk("held read rsp_rdata", 64'(rsp_rdata), 64'd0);
    model_clear();
    idle("post init idle");

    // Directed table, applied back to back.
    for (int i = 0; i < 16; i++) begin
      model_xact(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, e, r);
      xact($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata,
           tbl[i].be, tbl[i].err, tbl[i].rdata);
    end
    idle("tbl idle");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       raddr = AW'($urandom_range(0, DEP - 1) * 4);
      else if (sel == 7) raddr = AW'($urandom_range(0, DEP - 1) * 4 + $urandom_range(1, 3));
      else if (sel == 8) raddr = AW'($urandom_range(DEP, 4096) * 4);
      else               raddr = '0;
      rwe    = 1'($urandom_range(0, 1));
      rwdata = $urandom;
      rbe    = NB'($urandom_range(0, 15));
      model_xact(rwe, raddr, rwdata, rbe, e, r);
      xact($sformatf("rnd%0d", i), rwe, raddr, rwdata, rbe, e, r);
      if ($urandom_range(0, 3) == 0) idle($sformatf("rnd idle %0d", i));
    end
    idle("rnd end idle");

    // Reset during RUN with a read accepted in the same cycle.
    xact("pre-rst write", 1'b1, 32'h40, 32'h5555AAAA, 4'b1111, 1'b0, 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid-rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid-rst req_ready", 64'(req_ready), 64'd0);
    chk("mid-rst rsp_rdata", 64'(rsp_rdata), 64'd0);
    rst = 1'b0;
    init_poll("reinit");
    @(posedge clk); #1;
    chk("reinit read rsp_valid", 64'(rsp_valid), 64'd1);
    chk("reinit read rsp_err",   64'(rsp_err),   64'd0);
    chk("reinit read rsp_rdata", 64'(rsp_rdata), 64'd0);
    model_clear();
    xact("reinit read 0x10", 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 32'h0);
    idle("final idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
